// File: rtl/tb_uart_link_if.sv
// tb_uart_link_if: byte-level handshake between a requester and the bench-side UART.
interface tb_uart_link_if #(parameter int W = 8);
   logic         tx_start;
   logic [W-1:0] tx_data;
   logic         tx_busy;
   logic         tx_clear_req;
   logic [W-1:0] rx_data;
   logic         rx_valid;
   logic         rx_frame_err;
   modport master (output tx_start, tx_data, input tx_busy, tx_clear_req, rx_data, rx_valid, rx_frame_err);
   modport slave (input tx_start, tx_data, output tx_busy, tx_clear_req, rx_data, rx_valid, rx_frame_err);
endinterface

// File: rtl/tb_uart_link.sv
// tb_uart_link: independent 8N1 transmitter and receiver sharing one clock.
module tb_uart_link #(
   parameter int CLKS_PER_BIT = 4167,
   parameter int DATA_BITS = 8
) (
   input  logic clock,
   input  logic resetb,
   input  logic ser_rx,
   output logic ser_tx,
   tb_uart_link_if.slave bus
);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t tx_state, rx_state;
   logic [CW-1:0] tx_cnt, rx_cnt;
   logic [BW-1:0] tx_bit, rx_bit;
   logic [DATA_BITS-1:0] tx_shift, rx_shift;
   logic tx_prev, tx_armed, rx_s1, rx_s2, rx_s3;
   // tx_armed blocks a start that was already held high across reset release
   always_ff @(posedge clock) begin
      if (!resetb) begin
         tx_state <= IDLE;
         tx_cnt <= '0;
         tx_bit <= '0;
         tx_shift <= '0;
         tx_prev <= 1'b0;
         tx_armed <= 1'b0;
         ser_tx <= 1'b1;
         bus.tx_busy <= 1'b0;
         bus.tx_clear_req <= 1'b0;
      end else begin
         tx_prev <= bus.tx_start;
         if (!bus.tx_start) tx_armed <= 1'b1;
         bus.tx_clear_req <= 1'b0;
         case (tx_state)
            IDLE: if (bus.tx_start && !tx_prev && tx_armed) begin
               tx_shift <= bus.tx_data;
               tx_cnt <= '0;
               ser_tx <= 1'b0;
               bus.tx_busy <= 1'b1;
               tx_state <= START;
            end
            START: if (tx_cnt == LAST) begin
               tx_cnt <= '0;
               tx_bit <= '0;
               ser_tx <= tx_shift[0];
               tx_state <= DATA;
            end else tx_cnt <= tx_cnt + 1'b1;
            DATA: if (tx_cnt == LAST) begin
               tx_cnt <= '0;
               tx_shift <= tx_shift >> 1;
               tx_bit <= tx_bit + 1'b1;
               ser_tx <= (tx_bit == BLAST) ? 1'b1 : tx_shift[1];
               if (tx_bit == BLAST) tx_state <= STOP;
            end else tx_cnt <= tx_cnt + 1'b1;
            STOP: if (tx_cnt == LAST) begin
               tx_cnt <= '0;
               bus.tx_busy <= 1'b0;
               bus.tx_clear_req <= 1'b1;
               tx_state <= IDLE;
            end else tx_cnt <= tx_cnt + 1'b1;
         endcase
      end
   end
   // rx_s3 lags the synchroniser so only a high-to-low transition starts a frame
   always_ff @(posedge clock) begin
      if (!resetb) begin
         {rx_s1, rx_s2, rx_s3} <= 3'b111;
         rx_state <= IDLE;
         rx_cnt <= '0;
         rx_bit <= '0;
         rx_shift <= '0;
         bus.rx_data <= '0;
         bus.rx_valid <= 1'b0;
         bus.rx_frame_err <= 1'b0;
      end else begin
         rx_s1 <= ser_rx;
         rx_s2 <= rx_s1;
         rx_s3 <= rx_s2;
         bus.rx_valid <= 1'b0;
         bus.rx_frame_err <= 1'b0;
         case (rx_state)
            IDLE: if (rx_s3 && !rx_s2) begin
               rx_cnt <= '0;
               rx_state <= START;
            end
            START: if (rx_cnt == HALF) begin
               rx_cnt <= '0;
               rx_bit <= '0;
               rx_state <= rx_s2 ? IDLE : DATA;
            end else rx_cnt <= rx_cnt + 1'b1;
            DATA: if (rx_cnt == LAST) begin
               rx_cnt <= '0;
               rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
               rx_bit <= rx_bit + 1'b1;
               if (rx_bit == BLAST) rx_state <= STOP;
            end else rx_cnt <= rx_cnt + 1'b1;
            STOP: if (rx_cnt == LAST) begin
               rx_cnt <= '0;
               rx_state <= IDLE;
               if (rx_s2) begin
                  bus.rx_data <= rx_shift;
                  bus.rx_valid <= 1'b1;
               end else bus.rx_frame_err <= 1'b1;
            end else rx_cnt <= rx_cnt + 1'b1;
         endcase
      end
   end
endmodule

// File: tb/tb_tb_uart_link.sv
// tb_tb_uart_link: directed TX, RX, glitch, framing, loopback and mid-frame reset scenarios.
module tb_tb_uart_link;
   localparam int CPB = 16;
   logic clock = 1'b0;
   logic resetb = 1'b0;
   logic rx_drv = 1'b1;
   logic loop = 1'b0;
   logic ser_rx, ser_tx;
   tb_uart_link_if bus ();
   assign ser_rx = loop ? ser_tx : rx_drv;
   tb_uart_link #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
      .clock(clock), .resetb(resetb), .ser_rx(ser_rx), .ser_tx(ser_tx), .bus(bus)
   );
   always #5 clock = ~clock;
   int checks = 0, failures = 0;
   int valid_cnt = 0, err_cnt = 0, clr_cnt = 0, busy_run = 0, last_busy = 0;
   logic [7:0] rx_hist[$];
   always @(negedge clock) begin
      if (bus.rx_valid) begin
         valid_cnt++;
         rx_hist.push_back(bus.rx_data);
      end
      if (bus.rx_frame_err) err_cnt++;
      if (bus.tx_clear_req) clr_cnt++;
      if (bus.tx_busy) busy_run++;
      else if (busy_run != 0) begin
         last_busy = busy_run;
         busy_run = 0;
      end
   end
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask
   task automatic send_rx(input logic [7:0] b, input logic stop);
      rx_drv = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_drv = b[i];
         tick(CPB);
      end
      rx_drv = stop;
      tick(CPB);
      rx_drv = 1'b1;
      tick(CPB);
   endtask
   task automatic wait_clear(output logic ok);
      ok = 1'b0;
      for (int t = 0; t < 400 && !ok; t++) begin
         @(negedge clock);
         ok = bus.tx_clear_req;
      end
   endtask
   initial begin
      int n, v0, e0, c0, h0;
      logic ok;
      logic [9:0] exp_bits;
      logic [7:0] lb[3];
      bus.tx_start = 1'b1;
      bus.tx_data = 8'h00;
      tick(5);
      check("rst_ser_tx", ser_tx, 1);
      check("rst_busy", bus.tx_busy, 0);
      check("rst_clear", bus.tx_clear_req, 0);
      check("rst_valid", bus.rx_valid, 0);
      check("rst_ferr", bus.rx_frame_err, 0);
      check("rst_rx_data", bus.rx_data, 0);
      resetb = 1'b1;
      tick(3 * CPB);
      check("held_start_no_frame_busy", bus.tx_busy, 0);
      check("held_start_no_frame_clear", clr_cnt, 0);
      bus.tx_start = 1'b0;
      tick(2);
      // TX 0x3D: start, LSB-first data, stop; sampled mid-bit
      bus.tx_data = 8'h3D;
      bus.tx_start = 1'b1;
      n = 0;
      while (!bus.tx_busy && n < 4) begin
         @(negedge clock);
         n++;
      end
      check("tx_busy_latency_ok", n <= 2, 1);
      exp_bits = {1'b1, 8'h3D, 1'b0};
      for (int k = 0; k < 10; k++) begin
         repeat (8) @(negedge clock);
         check($sformatf("tx_bit%0d", k), ser_tx, exp_bits[k]);
         repeat (8) @(negedge clock);
      end
      bus.tx_start = 1'b0;
      tick(40);
      check("tx_clear_once", clr_cnt, 1);
      check("tx_busy_len", last_busy, 10 * CPB);
      check("tx_idle_after", bus.tx_busy, 0);
      check("tx_line_idle", ser_tx, 1);
      v0 = valid_cnt;
      e0 = err_cnt;
      send_rx(8'h0F, 1'b1);
      tick(20);
      check("rx0f_valid", valid_cnt - v0, 1);
      check("rx0f_data", bus.rx_data, 8'h0F);
      check("rx0f_no_ferr", err_cnt - e0, 0);
      rx_drv = 1'b0;
      tick(CPB / 4);
      rx_drv = 1'b1;
      tick(3 * CPB);
      check("glitch_no_valid", valid_cnt - v0, 1);
      check("glitch_no_ferr", err_cnt - e0, 0);
      send_rx(8'hA5, 1'b0);
      tick(20);
      check("ferr_pulse", err_cnt - e0, 1);
      check("ferr_no_valid", valid_cnt - v0, 1);
      check("ferr_data_kept", bus.rx_data, 8'h0F);
      // loopback, with a re-request mid-frame that must be ignored
      loop = 1'b1;
      lb[0] = 8'h00;
      lb[1] = 8'hFF;
      lb[2] = 8'h55;
      c0 = clr_cnt;
      v0 = valid_cnt;
      h0 = rx_hist.size();
      for (int i = 0; i < 3; i++) begin
         bus.tx_data = lb[i];
         bus.tx_start = 1'b1;
         if (i == 0) begin
            tick(30);
            bus.tx_start = 1'b0;
            tick(1);
            bus.tx_start = 1'b1;
         end
         wait_clear(ok);
         check($sformatf("lb_clear%0d", i), ok, 1);
         bus.tx_start = 1'b0;
         tick(1);
      end
      tick(40);
      check("lb_clear_count", clr_cnt - c0, 3);
      check("lb_valid_count", valid_cnt - v0, 3);
      for (int i = 0; i < 3; i++)
         check($sformatf("lb_byte%0d", i), (rx_hist.size() > h0 + i) ? rx_hist[h0+i] : 8'hxx, lb[i]);
      loop = 1'b0;
      tick(5);
      v0 = valid_cnt;
      e0 = err_cnt;
      c0 = clr_cnt;
      bus.tx_data = 8'h00;
      bus.tx_start = 1'b1;
      rx_drv = 1'b0;
      tick(3 * CPB + 5);
      check("mid_tx_low_before_rst", ser_tx, 0);
      resetb = 1'b0;
      tick(1);
      check("mid_rst_ser_tx", ser_tx, 1);
      check("mid_rst_busy", bus.tx_busy, 0);
      rx_drv = 1'b1;
      bus.tx_start = 1'b0;
      tick(2);
      resetb = 1'b1;
      tick(200);
      check("mid_rst_no_valid", valid_cnt - v0, 0);
      check("mid_rst_no_ferr", err_cnt - e0, 0);
      check("mid_rst_no_clear", clr_cnt - c0, 0);
      send_rx(8'hC3, 1'b1);
      tick(20);
      check("post_rst_rx_valid", valid_cnt - v0, 1);
      check("post_rst_rx_data", bus.rx_data, 8'hC3);
      bus.tx_data = 8'h81;
      bus.tx_start = 1'b1;
      wait_clear(ok);
      check("post_rst_tx_clear", ok, 1);
      bus.tx_start = 1'b0;
      tick(5);
      check("post_rst_tx_len", last_busy, 10 * CPB);
      check("post_rst_clear_count", clr_cnt - c0, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
